// File: rtl/cla_pkg.sv
// Shared carry-lookahead helpers and the ALU status-flag layout used by the adder and the ALU.
package cla_pkg;

  localparam int CLA_MAX_GRP_W = 32;
  localparam int CLA_MAX_NGRP  = 32;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic int ngrp(input int seg, input int group);
    return seg / group;
  endfunction

  // Group propagate/generate over the low n bits, returned as {P, G}.
  function automatic logic [1:0] grp_pg(input logic [CLA_MAX_GRP_W-1:0] a,
                                        input logic [CLA_MAX_GRP_W-1:0] b,
                                        input int n);
    logic p;
    logic g;
    p = 1'b1;
    g = 1'b0;
    for (int i = 0; i < CLA_MAX_GRP_W; i++) begin
      if (i < n) begin
        g = (a[i] & b[i]) | ((a[i] ^ b[i]) & g);
        p = p & (a[i] ^ b[i]);
      end
    end
    return {p, g};
  endfunction

  // Carry into group j, expanded as a flat sum of products over the lower groups.
  function automatic logic grp_carry(input logic [CLA_MAX_NGRP-1:0] p,
                                     input logic [CLA_MAX_NGRP-1:0] g,
                                     input logic cin,
                                     input int j);
    logic acc;
    logic prop;
    acc  = 1'b0;
    prop = 1'b1;
    for (int k = CLA_MAX_NGRP-1; k >= 0; k--) begin
      if (k < j) begin
        acc  = acc | (prop & g[k]);
        prop = prop & p[k];
      end
    end
    return acc | (prop & cin);
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational segment adder: per-group P/G, group-level lookahead carries, bit sums per group.
module cla_seg
  import cla_pkg::*;
#(
  parameter int SEG   = 16,
  parameter int GROUP = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  localparam int NGRP = ngrp(SEG, GROUP);

  logic [CLA_MAX_NGRP-1:0] w_p;
  logic [CLA_MAX_NGRP-1:0] w_g;

  always_comb begin : group_pg
    logic [CLA_MAX_GRP_W-1:0] ga;
    logic [CLA_MAX_GRP_W-1:0] gb;
    logic [1:0]               pg;
    w_p = '0;
    w_g = '0;
    ga  = '0;
    gb  = '0;
    pg  = '0;
    for (int gi = 0; gi < NGRP; gi++) begin
      ga = '0;
      gb = '0;
      ga[GROUP-1:0] = a[gi*GROUP +: GROUP];
      gb[GROUP-1:0] = b[gi*GROUP +: GROUP];
      pg = grp_pg(ga, gb, GROUP);
      w_p[gi] = pg[1];
      w_g[gi] = pg[0];
    end
  end

  // Within a group the bits ripple from the lookahead carry of that group.
  always_comb begin : bit_sum
    logic c;
    sum = '0;
    c   = 1'b0;
    for (int gi = 0; gi < NGRP; gi++) begin
      c = grp_carry(w_p, w_g, cin, gi);
      for (int bi = 0; bi < GROUP; bi++) begin
        sum[gi*GROUP+bi] = a[gi*GROUP+bi] ^ b[gi*GROUP+bi] ^ c;
        c = (a[gi*GROUP+bi] & b[gi*GROUP+bi]) | ((a[gi*GROUP+bi] ^ b[gi*GROUP+bi]) & c);
      end
    end
    cout = grp_carry(w_p, w_g, cin, NGRP);
  end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one segment per stage, valid/ready handshake, ALU flags.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG  = seg_w(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_cout;
  logic [WIDTH-1:0]  w_ain  [STAGES];
  logic [WIDTH-1:0]  w_bin  [STAGES];
  logic [WIDTH-1:0]  w_sout [STAGES];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k*SEG);
      logic [WIDTH-1:0] w_sin;
      logic [SEG-1:0]   w_seg;

      // Subtract is folded in here: b inverted and carry-in forced, so later stages never see sub.
      if (k == 0) begin : g_head
        assign w_ain[k] = a;
        assign w_bin[k] = sub ? ~b : b;
        assign w_cin[k] = sub | cin;
        assign w_sin    = '0;
        assign w_vin[k] = in_valid;
      end else begin : g_body
        assign w_ain[k] = r_a[k-1];
        assign w_bin[k] = r_b[k-1];
        assign w_cin[k] = r_c[k-1];
        assign w_sin    = r_s[k-1];
        assign w_vin[k] = r_vld[k-1];
      end

      cla_seg #(.SEG(SEG), .GROUP(GROUP)) u_seg (
        .a    (w_ain[k][k*SEG +: SEG]),
        .b    (w_bin[k][k*SEG +: SEG]),
        .cin  (w_cin[k]),
        .sum  (w_seg),
        .cout (w_cout[k])
      );

      assign w_sout[k] = (w_sin & ~SEG_MASK) | (WIDTH'(w_seg) << (k*SEG));
    end
  endgenerate

  // A stage may load when empty or when its successor moves on the same edge.
  always_comb begin
    w_adv       = '0;
    w_adv[LAST] = !r_vld[LAST] || out_ready;
    for (int k = LAST-1; k >= 0; k--) begin
      w_adv[k] = !r_vld[k] || w_adv[k+1];
    end
  end

  assign in_ready = w_adv[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_c   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= w_vin[k];
          if (w_vin[k]) begin
            r_a[k] <= w_ain[k];
            r_b[k] <= w_bin[k];
            r_s[k] <= w_sout[k];
            r_c[k] <= w_cout[k];
          end
        end
      end
    end
  end

  alu_flags_t w_flags;

  // zero is qualified by valid so the cleared sum after reset does not read as a zero result.
  always_comb begin
    w_flags.cout = r_c[LAST];
    w_flags.neg  = r_s[LAST][WIDTH-1];
    w_flags.zero = r_vld[LAST] && (r_s[LAST] == '0);
    w_flags.ovf  = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1]) &&
                   (r_s[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);
  end

  assign out_valid = r_vld[LAST];
  assign sum       = r_s[LAST];
  assign cout      = w_flags.cout;
  assign ovf       = w_flags.ovf;
  assign zero      = w_flags.zero;
  assign neg       = w_flags.neg;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub: three depth variants, flags, backpressure and mid-flight reset.
module tb_cla_pipe_addsub;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        sub;
  logic        cin;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;

  logic        in_ready_s1, out_valid_s1, cout_s1, ovf_s1, zero_s1, neg_s1;
  logic        in_ready_s2, out_valid_s2, cout_s2, ovf_s2, zero_s2, neg_s2;
  logic        in_ready_s4, out_valid_s4, cout_s4, ovf_s4, zero_s4, neg_s4;
  logic [31:0] sum_s1, sum_s2, sum_s4;

  int n_vec = 0;
  int n_err = 0;

  cla_pipe_addsub #(.WIDTH(32), .GROUP(8), .STAGES(2)) u_dut_s2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s2),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_s2), .out_ready(out_ready),
    .sum(sum_s2), .cout(cout_s2), .ovf(ovf_s2), .zero(zero_s2), .neg(neg_s2)
  );

  cla_pipe_addsub #(.WIDTH(32), .GROUP(8), .STAGES(1)) u_dut_s1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s1),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_s1), .out_ready(out_ready),
    .sum(sum_s1), .cout(cout_s1), .ovf(ovf_s1), .zero(zero_s1), .neg(neg_s1)
  );

  cla_pipe_addsub #(.WIDTH(32), .GROUP(4), .STAGES(4)) u_dut_s4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s4),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_s4), .out_ready(out_ready),
    .sum(sum_s4), .cout(cout_s4), .ovf(ovf_s4), .zero(zero_s4), .neg(neg_s4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat into all three variants; exp packs {cout, ovf, zero, neg, sum}.
  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vsub, input logic vcin, input logic [35:0] exp);
    int          lat1, lat2, lat4;
    logic [35:0] r1, r2, r4;
    lat1 = 0; lat2 = 0; lat4 = 0;
    r1 = '0; r2 = '0; r4 = '0;
    @(negedge clock);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = va; b = vb; sub = vsub; cin = vcin;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      if (out_valid_s1 && lat1 == 0) begin lat1 = cyc; r1 = {cout_s1, ovf_s1, zero_s1, neg_s1, sum_s1}; end
      if (out_valid_s2 && lat2 == 0) begin lat2 = cyc; r2 = {cout_s2, ovf_s2, zero_s2, neg_s2, sum_s2}; end
      if (out_valid_s4 && lat4 == 0) begin lat4 = cyc; r4 = {cout_s4, ovf_s4, zero_s4, neg_s4, sum_s4}; end
    end
    chk({tag, "_s2"},     64'(r2),   64'(exp));
    chk({tag, "_s2_lat"}, 64'(lat2), 64'd2);
    chk({tag, "_s1"},     64'(r1),   64'(exp));
    chk({tag, "_s1_lat"}, 64'(lat1), 64'd1);
    chk({tag, "_s4"},     64'(r4),   64'(exp));
    chk({tag, "_s4_lat"}, 64'(lat4), 64'd4);
  endtask

  initial begin
    int sent, recv, stray;
    logic saw_low;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid_s2), 64'd0);
    chk("rst_outputs",   64'({cout_s2, ovf_s2, zero_s2, neg_s2, sum_s2}), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready_s2), 64'd1);

    run_vec("add_ff",     32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {4'b0000, 32'h0000_0100});
    run_vec("add_seg",    32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, {4'b0000, 32'h0001_0000});
    run_vec("add_cin",    32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, {4'b0000, 32'h0000_0003});
    run_vec("wrap",       32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {4'b1010, 32'h0000_0000});
    run_vec("ovf_add",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {4'b0101, 32'h8000_0000});
    run_vec("ovf_sub",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, {4'b1100, 32'h7FFF_FFFF});
    run_vec("sub_borrow", 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, {4'b0001, 32'hFFFF_FFFE});
    run_vec("sub_pos",    32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, {4'b1000, 32'h0000_0002});
    run_vec("sub_zero",   32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, {4'b1010, 32'h0000_0000});

    // Eight beats a=b=i, consumer stalls for five cycles in the middle.
    sent = 0; recv = 0; saw_low = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(negedge clock);
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 8);
      sub = 1'b0; cin = 1'b0;
      a = 32'(sent + 1);
      b = 32'(sent + 1);
      #1;
      if (!out_ready && !in_ready_s2) saw_low = 1'b1;
      if (in_valid && in_ready_s2) sent++;
      if (out_valid_s2) begin
        if (out_ready) begin
          chk("bp_sum", 64'(sum_s2), 64'(2*(recv+1)));
          recv++;
        end else begin
          chk("bp_hold", 64'(sum_s2), 64'(2*(recv+1)));
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent",         64'(sent),    64'd8);
    chk("bp_recv",         64'(recv),    64'd8);
    chk("bp_inready_drop", 64'(saw_low), 64'd1);

    // Two beats in flight, then reset.
    @(negedge clock);
    out_ready = 1'b1; in_valid = 1'b1; sub = 1'b0; cin = 1'b0;
    a = 32'd10; b = 32'd20;
    @(negedge clock);
    a = 32'd30; b = 32'd40;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    chk("mid_valid",     64'(out_valid_s2), 64'd1);
    chk("mid_sum",       64'(sum_s2),       64'd30);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid_s2), 64'd0);
    chk("mid_rst_out",   64'({cout_s2, ovf_s2, zero_s2, neg_s2, sum_s2}), 64'd0);
    chk("mid_rst_s4",    64'(out_valid_s4), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready_s2), 64'd1);
    stray = 0;
    repeat (4) begin
      @(negedge clock);
      #1;
      if (out_valid_s2) stray++;
    end
    chk("rst_discard", 64'(stray), 64'd0);
    run_vec("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {4'b0000, 32'h2345_6789});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
